// File: rtl/mem_port_arbiter.sv
// Round-robin front end for a simple dual-port block RAM that writes every cycle.
// Idle writes are parked at the top address, and a sequencer zero-fills the usable range.
module mem_port_arbiter #(
   parameter int WID_MEM   = 5,
   parameter int DEPTH_MEM = 2048,
   parameter int ADDR_W    = 11
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               a_valid_i,
   input  logic               a_we_i,
   input  logic [ADDR_W-1:0]  a_addr_i,
   input  logic [WID_MEM-1:0] a_wdata_i,
   output logic               a_ready_o,
   output logic               a_err_o,
   input  logic               b_valid_i,
   input  logic               b_we_i,
   input  logic [ADDR_W-1:0]  b_addr_i,
   input  logic [WID_MEM-1:0] b_wdata_i,
   output logic               b_ready_o,
   output logic               b_err_o,
   output logic               rsp_valid_a_o,
   output logic               rsp_valid_b_o,
   output logic [WID_MEM-1:0] rsp_data_o,
   input  logic               clr_start_i,
   output logic               clr_busy_o,
   output logic               clr_done_o,
   output logic [31:0]        mem_raddr_o,
   output logic [31:0]        mem_waddr_o,
   output logic [WID_MEM-1:0] mem_din_o,
   input  logic [WID_MEM-1:0] mem_dout_i
);

   localparam logic [ADDR_W-1:0] PARK_A = ADDR_W'(DEPTH_MEM - 1);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH_MEM - 2);

   typedef enum logic {ST_ARB, ST_CLEAR} state_e;

   state_e              state_q, state_d;
   logic                rr_q, rr_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic                clr_done_q, clr_done_d;
   logic [1:0]          err_q, err_d;
   logic [1:0]          rsp_q, rsp_d;

   logic                in_arb;
   logic [1:0]          req_valid, req_we, req_oor, req_rd, req_wr;
   logic [1:0]          grant_rd, grant_wr, ready;
   logic [ADDR_W-1:0]   req_addr  [2];
   logic [WID_MEM-1:0]  req_wdata [2];
   logic [ADDR_W-1:0]   raddr_n, waddr_n;
   logic [WID_MEM-1:0]  din_n;

   assign in_arb       = (state_q == ST_ARB);
   assign req_valid    = {b_valid_i, a_valid_i};
   assign req_we       = {b_we_i, a_we_i};
   assign req_addr[0]  = a_addr_i;
   assign req_addr[1]  = b_addr_i;
   assign req_wdata[0] = a_wdata_i;
   assign req_wdata[1] = b_wdata_i;

   // Index 0 is requester A, index 1 is requester B; rr_q holds the index that wins a conflict.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign req_oor[gi]  = (req_addr[gi] >= PARK_A);
         assign req_rd[gi]   = in_arb & req_valid[gi] & ~req_oor[gi] & ~req_we[gi];
         assign req_wr[gi]   = in_arb & req_valid[gi] & ~req_oor[gi] &  req_we[gi];
         assign grant_rd[gi] = req_rd[gi] & (~req_rd[1-gi] | (rr_q == 1'(gi)));
         assign grant_wr[gi] = req_wr[gi] & (~req_wr[1-gi] | (rr_q == 1'(gi)));
         // Out-of-range requests are swallowed here without touching a memory port.
         assign ready[gi]    = in_arb & (~req_valid[gi] | req_oor[gi] | grant_rd[gi] | grant_wr[gi]);
         assign err_d[gi]    = in_arb & req_valid[gi] & req_oor[gi];
         assign rsp_d[gi]    = grant_rd[gi];
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      clr_cnt_d  = clr_cnt_q;
      clr_done_d = 1'b0;
      raddr_n    = '0;
      waddr_n    = PARK_A;
      din_n      = '0;
      case (state_q)
         ST_ARB: begin
            if ((&req_rd) | (&req_wr)) begin
               rr_d = ~rr_q;
            end
            if (grant_rd[0]) begin
               raddr_n = req_addr[0];
            end else if (grant_rd[1]) begin
               raddr_n = req_addr[1];
            end
            if (grant_wr[0]) begin
               waddr_n = req_addr[0];
               din_n   = req_wdata[0];
            end else if (grant_wr[1]) begin
               waddr_n = req_addr[1];
               din_n   = req_wdata[1];
            end
            if (clr_start_i) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            waddr_n = clr_cnt_q;
            if (clr_cnt_q == LAST_A) begin
               state_d    = ST_ARB;
               clr_cnt_d  = '0;
               clr_done_d = 1'b1;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_ARB;
         rr_q       <= 1'b0;
         clr_cnt_q  <= '0;
         clr_done_q <= 1'b0;
         err_q      <= '0;
         rsp_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         clr_cnt_q  <= clr_cnt_d;
         clr_done_q <= clr_done_d;
         err_q      <= err_d;
         rsp_q      <= rsp_d;
      end
   end

   assign a_ready_o     = ready[0];
   assign b_ready_o     = ready[1];
   assign a_err_o       = err_q[0];
   assign b_err_o       = err_q[1];
   assign rsp_valid_a_o = rsp_q[0];
   assign rsp_valid_b_o = rsp_q[1];
   assign rsp_data_o    = mem_dout_i;
   assign clr_busy_o    = (state_q == ST_CLEAR);
   assign clr_done_o    = clr_done_q;
   assign mem_raddr_o   = 32'(raddr_n);
   assign mem_waddr_o   = 32'(waddr_n);
   assign mem_din_o     = din_n;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter driving a behavioural read-first dual-port RAM.
// Each task covers one feature with hand-computed expectations.
module tb_mem_port_arbiter;
   localparam int WID = 5;
   localparam int DEPTH = 2048;
   localparam int AW = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic           a_valid, a_we, b_valid, b_we;
   logic [AW-1:0]  a_addr, b_addr;
   logic [WID-1:0] a_wdata, b_wdata;
   logic           a_ready, a_err, b_ready, b_err;
   logic           rsp_valid_a, rsp_valid_b;
   logic [WID-1:0] rsp_data;
   logic           clr_start, clr_busy, clr_done;
   logic [31:0]    mem_raddr, mem_waddr;
   logic [WID-1:0] mem_din, mem_dout;

   logic           pl_en;
   logic [AW-1:0]  pl_addr;
   logic [WID-1:0] pl_data;
   logic [WID-1:0] ram [0:DEPTH-1];

   int checks = 0;
   int passed = 0;

   mem_port_arbiter #(.WID_MEM(WID), .DEPTH_MEM(DEPTH), .ADDR_W(AW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .a_valid_i(a_valid), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
      .a_ready_o(a_ready), .a_err_o(a_err),
      .b_valid_i(b_valid), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
      .b_ready_o(b_ready), .b_err_o(b_err),
      .rsp_valid_a_o(rsp_valid_a), .rsp_valid_b_o(rsp_valid_b), .rsp_data_o(rsp_data),
      .clr_start_i(clr_start), .clr_busy_o(clr_busy), .clr_done_o(clr_done),
      .mem_raddr_o(mem_raddr), .mem_waddr_o(mem_waddr), .mem_din_o(mem_din),
      .mem_dout_i(mem_dout)
   );

   // Memory writes every cycle, read-first; preload steals the write port only while the DUT idles.
   always @(posedge clk) begin
      if (pl_en) ram[pl_addr] <= pl_data;
      else       ram[mem_waddr[AW-1:0]] <= mem_din;
      mem_dout <= ram[mem_raddr[AW-1:0]];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] addr, input logic [WID-1:0] d);
      pl_en = 1'b1; pl_addr = addr; pl_data = d;
      cyc();
      pl_en = 1'b0;
   endtask

   task automatic read_b(input logic [AW-1:0] addr, output logic v, output logic [WID-1:0] d);
      b_valid = 1'b1; b_we = 1'b0; b_addr = addr;
      cyc();
      b_valid = 1'b0;
      v = rsp_valid_b;
      d = rsp_data;
   endtask

   task automatic test_reset();
      logic bad;
      rst_n = 1'b0;
      preload(11'd5, 5'h1A);
      checks++;
      if ({a_ready, b_ready, a_err, b_err, rsp_valid_a, rsp_valid_b, clr_busy, clr_done} !== 8'b1100_0000)
         $display("FAIL reset_flags: got %b want 11000000",
                  {a_ready, b_ready, a_err, b_err, rsp_valid_a, rsp_valid_b, clr_busy, clr_done});
      else passed++;
      checks++;
      if (mem_raddr !== 32'd0 || mem_waddr !== 32'd2047 || mem_din !== 5'd0)
         $display("FAIL reset_mem: got raddr=%0d waddr=%0d din=%h want 0 2047 0", mem_raddr, mem_waddr, mem_din);
      else passed++;
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         cyc();
         bad = (mem_waddr !== 32'd2047) || (mem_din !== 5'd0) || (a_ready !== 1'b1) || (b_ready !== 1'b1);
         checks++;
         if (bad) $display("FAIL idle_park cycle %0d: got waddr=%0d din=%h rdy=%b%b want 2047 0 11",
                           i, mem_waddr, mem_din, a_ready, b_ready);
         else passed++;
      end
      checks++;
      if (ram[5] !== 5'h1A) $display("FAIL idle_preserve: got ram[5]=%h want 1a", ram[5]);
      else passed++;
   endtask

   task automatic test_read_first();
      logic v;
      logic [WID-1:0] d;
      a_valid = 1'b1; a_we = 1'b1; a_addr = 11'd5; a_wdata = 5'h13;
      b_valid = 1'b1; b_we = 1'b0; b_addr = 11'd5;
      #1;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b1 || mem_waddr !== 32'd5 || mem_din !== 5'h13 || mem_raddr !== 32'd5)
         $display("FAIL rw_grant: got rdy=%b%b waddr=%0d din=%h raddr=%0d want 11 5 13 5",
                  a_ready, b_ready, mem_waddr, mem_din, mem_raddr);
      else passed++;
      cyc();
      a_valid = 1'b0; b_valid = 1'b0;
      checks++;
      if (rsp_valid_b !== 1'b1 || rsp_valid_a !== 1'b0 || rsp_data !== 5'h1A)
         $display("FAIL rw_old_data: got vb=%b va=%b data=%h want 1 0 1a", rsp_valid_b, rsp_valid_a, rsp_data);
      else passed++;
      read_b(11'd5, v, d);
      checks++;
      if (v !== 1'b1 || d !== 5'h13) $display("FAIL rw_new_data: got v=%b data=%h want 1 13", v, d);
      else passed++;
   endtask

   task automatic test_round_robin();
      logic exp_a;
      preload(11'd1, 5'h01);
      preload(11'd2, 5'h02);
      for (int i = 0; i < 4; i++) begin
         a_valid = 1'b1; a_we = 1'b0; a_addr = 11'd1;
         b_valid = 1'b1; b_we = 1'b0; b_addr = 11'd2;
         #1;
         exp_a = (i % 2 == 0);
         checks++;
         if (a_ready !== exp_a || b_ready !== !exp_a || mem_raddr !== (exp_a ? 32'd1 : 32'd2))
            $display("FAIL rr_grant %0d: got rdy=%b%b raddr=%0d want %b%b %0d",
                     i, a_ready, b_ready, mem_raddr, exp_a, !exp_a, exp_a ? 1 : 2);
         else passed++;
         if (i > 0) begin
            checks++;
            if (rsp_valid_a !== !exp_a || rsp_valid_b !== exp_a || rsp_data !== (exp_a ? 5'h02 : 5'h01))
               $display("FAIL rr_rsp %0d: got va=%b vb=%b data=%h want %b %b %h",
                        i, rsp_valid_a, rsp_valid_b, rsp_data, !exp_a, exp_a, exp_a ? 5'h02 : 5'h01);
            else passed++;
         end
         cyc();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      checks++;
      if (rsp_valid_a !== 1'b0 || rsp_valid_b !== 1'b1 || rsp_data !== 5'h02)
         $display("FAIL rr_rsp_last: got va=%b vb=%b data=%h want 0 1 02", rsp_valid_a, rsp_valid_b, rsp_data);
      else passed++;
   endtask

   task automatic test_out_of_range();
      a_valid = 1'b1; a_we = 1'b1; a_addr = 11'd2047; a_wdata = 5'h1F;
      #1;
      checks++;
      if (a_ready !== 1'b1 || mem_waddr !== 32'd2047 || mem_din !== 5'd0)
         $display("FAIL oor_wr_accept: got rdy=%b waddr=%0d din=%h want 1 2047 0", a_ready, mem_waddr, mem_din);
      else passed++;
      cyc();
      a_valid = 1'b0;
      checks++;
      if (a_err !== 1'b1 || b_err !== 1'b0) $display("FAIL oor_wr_err: got a_err=%b b_err=%b want 1 0", a_err, b_err);
      else passed++;
      cyc();
      checks++;
      if (a_err !== 1'b0 || ram[2047] !== 5'd0)
         $display("FAIL oor_wr_after: got a_err=%b ram[2047]=%h want 0 0", a_err, ram[2047]);
      else passed++;
      b_valid = 1'b1; b_we = 1'b0; b_addr = 11'd2047;
      #1;
      checks++;
      if (b_ready !== 1'b1 || mem_raddr !== 32'd0)
         $display("FAIL oor_rd_accept: got rdy=%b raddr=%0d want 1 0", b_ready, mem_raddr);
      else passed++;
      cyc();
      b_valid = 1'b0;
      checks++;
      if (b_err !== 1'b1 || rsp_valid_b !== 1'b0 || a_err !== 1'b0)
         $display("FAIL oor_rd_err: got b_err=%b vb=%b a_err=%b want 1 0 0", b_err, rsp_valid_b, a_err);
      else passed++;
      a_valid = 1'b1; a_we = 1'b1; a_addr = 11'd2047; a_wdata = 5'h1F;
      b_valid = 1'b1; b_we = 1'b1; b_addr = 11'd3;    b_wdata = 5'h0C;
      #1;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b1 || mem_waddr !== 32'd3 || mem_din !== 5'h0C)
         $display("FAIL oor_no_port: got rdy=%b%b waddr=%0d din=%h want 11 3 0c", a_ready, b_ready, mem_waddr, mem_din);
      else passed++;
      cyc();
      a_valid = 1'b0; b_valid = 1'b0;
      checks++;
      if (ram[3] !== 5'h0C || a_err !== 1'b1 || b_err !== 1'b0)
         $display("FAIL oor_other_write: got ram[3]=%h a_err=%b b_err=%b want 0c 1 0", ram[3], a_err, b_err);
      else passed++;
   endtask

   task automatic test_clear();
      int n;
      logic bad;
      logic v;
      logic [WID-1:0] d;
      logic [AW-1:0] probe [3];
      probe[0] = 11'd0; probe[1] = 11'd1023; probe[2] = 11'd2046;
      for (int i = 0; i < 3; i++) preload(probe[i], 5'h11 + 5'(i));
      clr_start = 1'b1;
      cyc();
      clr_start = 1'b0;
      n = 0;
      bad = 1'b0;
      while (clr_busy === 1'b1 && n < 4000) begin
         if (a_ready !== 1'b0 || b_ready !== 1'b0 || clr_done !== 1'b0) bad = 1'b1;
         clr_start = (n == 100);
         n++;
         cyc();
      end
      clr_start = 1'b0;
      checks++;
      if (n !== 2047) $display("FAIL clr_duration: got %0d busy cycles want 2047", n);
      else passed++;
      checks++;
      if (bad) $display("FAIL clr_busy_flags: got ready or done during clear want 0");
      else passed++;
      checks++;
      if (clr_done !== 1'b1 || a_ready !== 1'b1 || mem_waddr !== 32'd2047 || mem_din !== 5'd0)
         $display("FAIL clr_exit: got done=%b rdy=%b waddr=%0d din=%h want 1 1 2047 0", clr_done, a_ready, mem_waddr, mem_din);
      else passed++;
      cyc();
      checks++;
      if (clr_done !== 1'b0 || clr_busy !== 1'b0)
         $display("FAIL clr_done_pulse: got done=%b busy=%b want 0 0", clr_done, clr_busy);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         read_b(probe[i], v, d);
         checks++;
         if (v !== 1'b1 || d !== 5'd0) $display("FAIL clr_zero addr %0d: got v=%b data=%h want 1 00", probe[i], v, d);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_clear();
      logic seen_done;
      logic v;
      logic [WID-1:0] d;
      logic [AW-1:0] probe [4];
      logic [WID-1:0] expd [4];
      probe[0] = 11'd0;  expd[0] = 5'h00;
      probe[1] = 11'd9;  expd[1] = 5'h00;
      probe[2] = 11'd10; expd[2] = 5'h0B;
      probe[3] = 11'd20; expd[3] = 5'h0B;
      for (int i = 0; i < 4; i++) preload(probe[i], 5'h0B);
      clr_start = 1'b1;
      cyc();
      clr_start = 1'b0;
      repeat (10) cyc();
      rst_n = 1'b0;
      #1;
      checks++;
      if (clr_busy !== 1'b0 || clr_done !== 1'b0 || mem_waddr !== 32'd2047)
         $display("FAIL rst_abort: got busy=%b done=%b waddr=%0d want 0 0 2047", clr_busy, clr_done, mem_waddr);
      else passed++;
      cyc();
      cyc();
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (clr_done !== 1'b0 || clr_busy !== 1'b0) seen_done = 1'b1;
      end
      checks++;
      if (seen_done) $display("FAIL rst_no_done: got done/busy after abort want 0");
      else passed++;
      for (int i = 0; i < 4; i++) begin
         read_b(probe[i], v, d);
         checks++;
         if (v !== 1'b1 || d !== expd[i])
            $display("FAIL rst_partial addr %0d: got v=%b data=%h want 1 %h", probe[i], v, d, expd[i]);
         else passed++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      clr_start = 1'b0;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      cyc();
      test_reset();
      test_read_first();
      test_round_robin();
      test_out_of_range();
      test_clear();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester controller for the team's simple dual-port inferred block RAM: 1 read port, 1 write port, registered read data.
- That memory writes `ram[waddr] <= din` on every clock, so this block parks all idle write traffic at a reserved sacrificial address.
- Arbitrates requesters A and B round-robin and returns tagged read responses.
- Contains a clear sequencer that zero-fills the usable address range on command.

Parameters:
- WID_MEM, 5, data width (matches memory WID_MEM).
- DEPTH_MEM, 2048, memory depth; address DEPTH_MEM-1 is PARK_ADDR, not requester-usable.
- ADDR_W, 11, requester address width; requires 2**ADDR_W >= DEPTH_MEM.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A request valid.
- a_we  in  1  A: 1=write, 0=read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  WID_MEM  A write data.
- a_ready  out  1  A request accepted this cycle when a_valid&a_ready.
- a_err  out  1  1-cycle pulse: accepted A request had addr >= PARK_ADDR.
- b_valid, b_we, b_addr, b_wdata, b_ready, b_err: same as A, for requester B.
- rsp_valid_a  out  1  read data for A valid on rsp_data.
- rsp_valid_b  out  1  read data for B valid on rsp_data.
- rsp_data  out  WID_MEM  read data (memory dout passed through).
- clr_start  in  1  pulse: begin zero-fill.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  1-cycle pulse at clear completion.
- mem_raddr  out  32  to memory raddr.
- mem_waddr  out  32  to memory waddr.
- mem_din  out  WID_MEM  to memory din.
- mem_dout  in  WID_MEM  from memory dout (1-cycle registered read).

Behaviour:
- States: ARB, CLEAR. Reset → ARB, rr_ptr=A, clr_cnt=0; all pulse/valid outputs 0, clr_busy=0, mem_raddr=0, mem_waddr=PARK_ADDR, mem_din=0.
- mem_* outputs are combinational from state and grants. mem_raddr/mem_waddr are zero-extended to 32 bits.
- Idle write: whenever no write is granted, mem_waddr=PARK_ADDR and mem_din=0. This holds every cycle, including ARB with no write and the cycle after CLEAR.
- Idle read: whenever no read is granted, mem_raddr=0.
- ARB grants:
  - A read and a write from different requesters are both granted in the same cycle (one uses the read port, one the write port).
  - Both requesters read, or both write: conflict. rr_ptr wins; rr_ptr then toggles to the loser. rr_ptr changes only on a conflict.
  - A single requester is always granted.
  - Ready may depend combinationally on valid. Requesters must hold request fields stable while valid&!ready.
- Out-of-range request (addr >= PARK_ADDR): accepted (ready=1), err pulses the next cycle, no memory access.
  - Rejected write: mem_waddr stays PARK_ADDR.
  - Rejected read: no rsp_valid.
  - A rejected request does not consume a port; the other requester's same-type request is granted that cycle.
- Read latency: accepted read in cycle N → rsp_valid_x=1 and rsp_data=ram[addr] in cycle N+1. At most one rsp_valid high per cycle.
- Same-cycle read/write to the same address: read returns the old data (read-first).
- clr_start in ARB: that cycle's grants proceed normally; CLEAR begins next cycle. clr_start during CLEAR is ignored.
- CLEAR:
  - a_ready=b_ready=0, clr_busy=1.
  - Each cycle: mem_waddr=clr_cnt, mem_din=0, clr_cnt++.
  - After address PARK_ADDR-1 is written: clr_done pulses the next cycle, state returns to ARB, clr_cnt returns to 0.
  - Duration: DEPTH_MEM-1 busy cycles.
- Reset asserted mid-clear: abort immediately to reset values. Already-written addresses stay zero; no clr_done.
- Reset is asserted asynchronously; deassertion is synchronous to clk.

Test Plan:
- Reset release, no requests → a_ready=b_ready=1 (combinational on valid), mem_waddr=2047, mem_din=0 every cycle; preloaded ram[5]=0x1A unchanged after 100 cycles.
- A writes addr 5 = 0x13 while B reads addr 5 in the same cycle → both ready; rsp_valid_b next cycle with 0x1A (old). B reads addr 5 again → 0x13.
- A and B both read (A addr 1, B addr 2) for 4 consecutive cycles → grants alternate A,B,A,B; each loser is held until granted; rsp ordering matches grants.
- A write to addr 2047 → a_ready=1, a_err pulses next cycle, ram[2047] keeps parking value 0. B read of addr 2047 → b_err pulse, no rsp_valid_b.
- clr_start with memory preloaded non-zero → clr_busy for 2047 cycles, readies 0; clr_done pulse; reads of addrs 0, 1023, 2046 return 0.
- Reset pulsed 10 cycles into a clear → clr_busy drops immediately, no clr_done. Addrs 0–9 read 0; addr 20 retains its preload.
